led7seg_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display controller. It replaces the fixed six-digit scanner with a configurable one. Host logic writes glyph codes into a per-digit register file. The block time-multiplexes the digits from the 1 ms strobe, inserting a one-cycle ghost blank at each change. It adds per-digit blinking, PWM brightness and optional decimal points, and drives the LED enable and segment pins of the front-panel display directly.

---
 rtl/led7seg_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_led7seg_scan_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/led7seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: per-digit glyph registers, ghost blanking, blink and PWM dimming.
// Optional per-digit decimal points are built when LED7SEG_DP_EN is defined.
module led7seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS     = 6,
   parameter int unsigned SCAN_DIV       = 1,
   parameter int unsigned PWM_BITS       = 3,
   parameter bit          EN_ACTIVE_LOW  = 1'b0,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                  Mclk,
   input  logic                  ResetN,
   input  logic                  Strobe1ms,
   input  logic                  Strobe125ms,
   input  logic                  DigitWr,
   input  logic [2:0]            DigitAddr,
   input  logic [4:0]            DigitData,
   input  logic                  DigitDp,
   input  logic [NUM_DIGITS-1:0] BlinkMask,
   input  logic [PWM_BITS-1:0]   Brightness,
   output logic [NUM_DIGITS-1:0] Led7En,
   output logic [6:0]            Led7Leg,
   output logic                  Led7Dp,
   output logic                  FrameDone
);

   localparam int unsigned SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [NUM_DIGITS-1:0] EN_OFF  = {NUM_DIGITS{EN_ACTIVE_LOW}};
   localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};

   function automatic logic [6:0] decode(input logic [4:0] code);
      logic [6:0] seg;
      case (code)
         5'h00: seg = 7'h3F;  5'h01: seg = 7'h06;  5'h02: seg = 7'h5B;  5'h03: seg = 7'h4F;
         5'h04: seg = 7'h66;  5'h05: seg = 7'h6D;  5'h06: seg = 7'h7D;  5'h07: seg = 7'h27;
         5'h08: seg = 7'h7F;  5'h09: seg = 7'h67;  5'h0A: seg = 7'h77;  5'h0B: seg = 7'h7C;
         5'h0C: seg = 7'h39;  5'h0D: seg = 7'h5E;  5'h0E: seg = 7'h79;  5'h0F: seg = 7'h71;
         5'h11: seg = 7'h40;  5'h12: seg = 7'h48;  5'h13: seg = 7'h54;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   logic                  s1_q, s2_q, tick_q;
   logic [DIV_W-1:0]      div_q;
   logic [SLOT_W-1:0]     slot_q;
   logic                  run_q;
   logic [4:0]            glyph_q [NUM_DIGITS];
   logic [4:0]            pat_q;
   logic                  pat_phase_q;
   logic [PWM_BITS-1:0]   pwm_q;
   logic [1:0]            bcnt_q;
   logic                  phase_q;

   logic                  slot_start_c;
   logic [SLOT_W-1:0]     next_slot_c;
   logic [SLOT_W-1:0]     cur_slot_c;
   logic [4:0]            src_glyph_c;
   logic [4:0]            show_glyph_c;
   logic                  mask_c;
   logic                  blank_c;
   logic [NUM_DIGITS-1:0] onehot_c;
   logic                  pwm_on_c;

   // Slot sequencing and the pattern that is shown during the current or starting slot
   always_comb begin
      slot_start_c = tick_q && (div_q == DIV_W'(SCAN_DIV - 1));
      next_slot_c  = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
      cur_slot_c   = slot_start_c ? next_slot_c : slot_q;
      src_glyph_c  = 5'h10;
      mask_c       = 1'b0;
      onehot_c     = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (next_slot_c == SLOT_W'(i)) src_glyph_c = glyph_q[i];
         if (cur_slot_c == SLOT_W'(i))  mask_c      = BlinkMask[i];
         if (slot_q == SLOT_W'(i))      onehot_c[i] = 1'b1;
      end
      show_glyph_c = slot_start_c ? src_glyph_c : pat_q;
      blank_c      = (slot_start_c ? phase_q : pat_phase_q) & mask_c;
      pwm_on_c     = (pwm_q <= Brightness);
   end

   always_ff @(posedge Mclk or negedge ResetN) begin
      if (!ResetN) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         tick_q      <= 1'b0;
         div_q       <= '0;
         slot_q      <= SLOT_W'(NUM_DIGITS - 1);
         run_q       <= 1'b0;
         pat_q       <= 5'h10;
         pat_phase_q <= 1'b0;
         pwm_q       <= '0;
         bcnt_q      <= '0;
         phase_q     <= 1'b0;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) glyph_q[i] <= 5'h10;
         Led7En      <= EN_OFF;
         Led7Leg     <= SEG_OFF;
         FrameDone   <= 1'b0;
      end else begin
         s1_q   <= Strobe1ms;
         s2_q   <= s1_q;
         tick_q <= s1_q & ~s2_q;
         pwm_q  <= pwm_q + PWM_BITS'(1);
         if (tick_q) div_q <= slot_start_c ? '0 : div_q + DIV_W'(1);
         if (slot_start_c) begin
            slot_q      <= next_slot_c;
            run_q       <= 1'b1;
            pat_q       <= src_glyph_c;
            pat_phase_q <= phase_q;
         end
         // Phase toggles when the 2-bit blink counter wraps: 500 ms on, 500 ms off
         if (Strobe125ms) begin
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) phase_q <= ~phase_q;
         end
         for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (DigitWr && (DigitAddr == 3'(i))) glyph_q[i] <= DigitData;
         Led7En    <= (slot_start_c || !run_q) ? EN_OFF
                      : (onehot_c & {NUM_DIGITS{pwm_on_c}}) ^ EN_OFF;
         Led7Leg   <= (blank_c ? 7'h00 : decode(show_glyph_c)) ^ SEG_OFF;
         FrameDone <= slot_start_c && (next_slot_c == '0);
      end
   end

`ifdef LED7SEG_DP_EN
   logic dp_q [NUM_DIGITS];
   logic pat_dp_q;
   logic src_dp_c;
   logic show_dp_c;

   always_comb begin
      src_dp_c = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
         if (next_slot_c == SLOT_W'(i)) src_dp_c = dp_q[i];
      show_dp_c = (slot_start_c ? src_dp_c : pat_dp_q) & ~blank_c;
   end

   always_ff @(posedge Mclk or negedge ResetN) begin
      if (!ResetN) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) dp_q[i] <= 1'b0;
         pat_dp_q <= 1'b0;
         Led7Dp   <= SEG_ACTIVE_LOW;
      end else begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (DigitWr && (DigitAddr == 3'(i))) dp_q[i] <= DigitDp;
         if (slot_start_c) pat_dp_q <= src_dp_c;
         Led7Dp <= show_dp_c ^ SEG_ACTIVE_LOW;
      end
   end
`else
   logic unused_dp;
   assign unused_dp = DigitDp;
   assign Led7Dp    = SEG_ACTIVE_LOW;
`endif

endmodule

// File: tb/tb_led7seg_scan_ctrl.sv
// Randomized scoreboard bench for led7seg_scan_ctrl in its default configuration.
module tb_led7seg_scan_ctrl;
   localparam int N        = 6;
   localparam int SCAN_DIV = 1;

   logic       Mclk = 1'b0, ResetN = 1'b0;
   logic       Strobe1ms = 1'b0, Strobe125ms = 1'b0;
   logic       DigitWr = 1'b0, DigitDp = 1'b0;
   logic [2:0] DigitAddr = '0;
   logic [4:0] DigitData = '0;
   logic [N-1:0] BlinkMask = '0;
   logic [2:0] Brightness = 3'd7;
   logic [N-1:0] Led7En;
   logic [6:0] Led7Leg;
   logic       Led7Dp, FrameDone;

   led7seg_scan_ctrl dut (
      .Mclk(Mclk), .ResetN(ResetN), .Strobe1ms(Strobe1ms), .Strobe125ms(Strobe125ms),
      .DigitWr(DigitWr), .DigitAddr(DigitAddr), .DigitData(DigitData), .DigitDp(DigitDp),
      .BlinkMask(BlinkMask), .Brightness(Brightness), .Led7En(Led7En), .Led7Leg(Led7Leg),
      .Led7Dp(Led7Dp), .FrameDone(FrameDone)
   );

   always #5 Mclk = ~Mclk;

   typedef struct { logic [6:0] leg; logic fd; logic [N-1:0] en; } exp_t;

   logic [6:0] seg_tab [32] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
      7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
      7'h00, 7'h40, 7'h48, 7'h54, 7'h00, 7'h00, 7'h00, 7'h00,
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

   int checks = 0, failures = 0;
   logic [4:0] m_dig [N];
   int m_slot, m_ticks, m_blinks;
   exp_t q[$];
   bit mon_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_dig[i] = 5'h10;
      m_slot = N - 1; m_ticks = 0; m_blinks = 0;
   endtask

   task automatic wr(input int a, input logic [4:0] d);
      @(negedge Mclk);
      DigitWr = 1'b1; DigitAddr = 3'(a); DigitData = d; DigitDp = 1'($urandom);
      @(negedge Mclk);
      DigitWr = 1'b0;
      if (a < N) m_dig[a] = d;
   endtask

   // One strobe rising edge; the model decides whether it starts a slot
   task automatic strobe(input int len);
      exp_t e;
      @(negedge Mclk);
      Strobe1ms = 1'b1;
      m_ticks++;
      if (m_ticks % SCAN_DIV == 0) begin
         m_slot = (m_slot + 1) % N;
         e.leg = (((m_blinks / 4) % 2 == 1) && BlinkMask[m_slot]) ? 7'h00 : seg_tab[m_dig[m_slot]];
         e.en  = N'(1 << m_slot);
         e.fd  = (m_slot == 0);
         q.push_back(e);
      end
      repeat (len) @(negedge Mclk);
      Strobe1ms = 1'b0;
      repeat (8) @(negedge Mclk);
   endtask

   task automatic blink();
      @(negedge Mclk); Strobe125ms = 1'b1;
      @(negedge Mclk); Strobe125ms = 1'b0;
      m_blinks++;
   endtask

   task automatic pwm_count(input logic [2:0] b);
      int on_cnt, stray;
      logic [N-1:0] oh;
      oh = N'(1 << m_slot);
      on_cnt = 0; stray = 0;
      @(negedge Mclk); Brightness = b;
      repeat (2) @(negedge Mclk);
      repeat (64) begin
         @(negedge Mclk);
         if (Led7En == oh) on_cnt++;
         else if (Led7En != '0) stray++;
      end
      chk("pwm_on_cycles", on_cnt, 8 * (int'(b) + 1));
      chk("pwm_stray_en", stray, 0);
   endtask

   // Monitor: a slot start shows as a ghost-blank cycle followed by an enable
   logic [N-1:0] p_en = '0;
   logic [6:0]   p_leg = '0;
   logic         p_fd = 1'b0;
   always @(negedge Mclk) begin
      exp_t e;
      if (mon_en && ResetN && p_en == '0 && Led7En != '0) begin
         chk("pending_expect", int'(q.size() != 0), 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("slot_leg", p_leg, e.leg);
            chk("slot_framedone", p_fd, e.fd);
            chk("slot_en", Led7En, e.en);
         end
         chk("dp_idle", Led7Dp, 0);
      end
      if (FrameDone) chk("framedone_in_ghost", Led7En, 0);
      p_en = Led7En; p_leg = Led7Leg; p_fd = FrameDone;
   end

   initial begin
      int guard;
      model_reset();
      repeat (3) @(negedge Mclk);
      chk("rst_en", Led7En, 0);
      chk("rst_leg", Led7Leg, 0);
      chk("rst_dp", Led7Dp, 0);
      chk("rst_framedone", FrameDone, 0);
      ResetN = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge Mclk);

      for (int i = 0; i < N; i++) wr(i, 5'(i + 1));
      repeat (N) strobe(1);

      wr(7, 5'h00);
      wr(6, 5'h1F);
      repeat (N) strobe(1);

      for (int i = 0; i < N; i++) wr(i, 5'($urandom_range(0, 31)));
      repeat (N) strobe($urandom_range(1, 4));

      BlinkMask = 6'b000001;
      for (int k = 0; k < 8; k++) begin
         blink();
         repeat (N) strobe(1);
      end

      strobe(50);
      BlinkMask = N'($urandom);
      for (int k = 0; k < 5; k++) blink();
      repeat (12) strobe($urandom_range(1, 50));

      repeat (20) begin
         if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 7), 5'($urandom));
         strobe($urandom_range(1, 6));
      end

      mon_en = 1'b0;
      pwm_count(3'd3);
      pwm_count(3'd7);
      pwm_count(3'($urandom_range(0, 6)));
      Brightness = 3'd7;
      repeat (4) @(negedge Mclk);
      mon_en = 1'b1;

      BlinkMask = '0;
      wr(3, 5'h03);
      guard = 0;
      while (m_slot != 3 && guard < 2 * N) begin
         strobe(1);
         guard++;
      end
      repeat (5) @(negedge Mclk);
      chk("pre_reset_leg", Led7Leg, 7'h4F);
      ResetN = 1'b0;
      #1;
      chk("async_rst_en", Led7En, 0);
      chk("async_rst_leg", Led7Leg, 0);
      chk("async_rst_dp", Led7Dp, 0);
      model_reset();
      repeat (3) @(negedge Mclk);
      ResetN = 1'b1;
      repeat (3) @(negedge Mclk);
      chk("post_rst_idle_en", Led7En, 0);
      strobe(1);
      strobe(2);

      guard = 0;
      while (q.size() != 0 && guard < 100) begin
         @(negedge Mclk);
         guard++;
      end
      chk("scoreboard_drain", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
